cmd_fetch_bram: RTL and testbench

CMD_FETCH_BRAM -- requirements
Module: cmd_fetch_bram

---
 rtl/cmd_fetch_bram.sv | 160 ++++++++++++++++
 tb/tb_cmd_fetch_bram.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fetch_bram.sv
// cmd_fetch_bram: dual-access block RAM with a bus port (BRAM_*) and a
// burst fetch streamer (fetch_*) that share one memory array.
// Optional feature macro: CMD_FETCH_BYTE_WRITE_EN
//   defined   -> each BRAM_wen bit writes only its own byte lane
//   undefined -> any BRAM_wen bit writes the whole word
// Bus vectors use ascending bit order: lane 0 is bits [0:7], the most
// significant byte of the stored word.
module cmd_fetch_bram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 8,
    localparam int BURST_W  = $clog2(MAX_BURST + 1)
) (
    input  logic                BRAM_clk,
    input  logic                BRAM_rst,
    input  logic                BRAM_en,
    input  logic [0:DATA_W/8-1] BRAM_wen,
    input  logic [0:31]         BRAM_addr,
    input  logic [0:DATA_W-1]   BRAM_dout,
    output logic [0:DATA_W-1]   BRAM_din,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    input  logic [BURST_W-1:0]  fetch_len,
    output logic                fetch_busy,
    output logic [DATA_W-1:0]   fetch_data,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic                fetch_last,
    output logic                fetch_done
);

    typedef enum logic [1:0] {IDLE, READ, STREAM} state_t;

    logic [DATA_W-1:0]  mem [0:(1<<ADDR_W)-1];

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  bus_word;
    logic [DATA_W-1:0]  wr_word;
    logic               bus_we;
    logic [ADDR_W-1:0]  rd_addr;
    logic [BURST_W-1:0] remaining;
    logic               reject_done;
    logic               accept;
    logic               len_ok;
    logic               unused_addr_bits;

    // Byte address -> word address; the byte offset and high bits are unused
    assign bus_word         = BRAM_addr[30-ADDR_W:29];
    assign unused_addr_bits = ^{BRAM_addr[0:29-ADDR_W], BRAM_addr[30:31]};
    assign wr_word          = BRAM_dout;
    assign bus_we           = BRAM_en && (|BRAM_wen);
    assign len_ok           = (fetch_len != '0) && (fetch_len <= BURST_W'(MAX_BURST));
    assign fetch_done       = (accept && fetch_last) || reject_done;

    // Bus write port; reset only blocks writes and never clears the array
    always_ff @(posedge BRAM_clk or posedge BRAM_rst) begin
        if (BRAM_rst) begin
        end else if (bus_we) begin
`ifdef CMD_FETCH_BYTE_WRITE_EN
            for (int i = 0; i < DATA_W/8; i++) begin
                if (BRAM_wen[i]) begin
                    mem[bus_word][DATA_W-1-8*i -: 8] <= wr_word[DATA_W-1-8*i -: 8];
                end
            end
`else
            mem[bus_word] <= wr_word;
`endif
        end
    end

    // Bus read port: registered, old data returned on a same-address write
    always_ff @(posedge BRAM_clk or posedge BRAM_rst) begin
        if (BRAM_rst) begin
            BRAM_din <= '0;
        end else if (BRAM_en) begin
            BRAM_din <= mem[bus_word];
        end
    end

    // Fetch FSM state register
    always_ff @(posedge BRAM_clk or posedge BRAM_rst) begin
        if (BRAM_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM next-state and handshake outputs
    always_comb begin
        state_next  = state;
        fetch_busy  = 1'b0;
        fetch_valid = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && len_ok) begin
                    state_next = READ;
                end
            end
            READ: begin
                fetch_busy = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                fetch_busy  = 1'b1;
                fetch_valid = 1'b1;
                accept      = fetch_ready;
                if (fetch_ready && fetch_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetch datapath: the output register is refilled by a synchronous read
    // on the same edge that retires the current word, so words stream with
    // no bubble and a word is read as late as possible (sees recent writes)
    always_ff @(posedge BRAM_clk or posedge BRAM_rst) begin
        if (BRAM_rst) begin
            rd_addr     <= '0;
            remaining   <= '0;
            fetch_data  <= '0;
            fetch_last  <= 1'b0;
            reject_done <= 1'b0;
        end else begin
            reject_done <= (state == IDLE) && fetch_req && !len_ok;
            case (state)
                IDLE: begin
                    if (fetch_req && len_ok) begin
                        rd_addr   <= fetch_addr;
                        remaining <= fetch_len;
                    end
                end
                READ: begin
                    fetch_data <= mem[rd_addr];
                    rd_addr    <= rd_addr + ADDR_W'(1);
                    fetch_last <= (remaining == BURST_W'(1));
                end
                STREAM: begin
                    if (accept) begin
                        if (fetch_last) begin
                            fetch_last <= 1'b0;
                        end else begin
                            fetch_data <= mem[rd_addr];
                            rd_addr    <= rd_addr + ADDR_W'(1);
                            remaining  <= remaining - BURST_W'(1);
                            fetch_last <= (remaining == BURST_W'(2));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_fetch_bram.sv
// tb_cmd_fetch_bram: directed and randomized checks of cmd_fetch_bram
// against a simple array model of the memory contents.
module tb_cmd_fetch_bram;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 10;
    localparam int MAX_BURST = 8;
    localparam int BURST_W   = $clog2(MAX_BURST + 1);
    localparam int DEPTH     = 1 << ADDR_W;

    logic               BRAM_clk;
    logic               BRAM_rst;
    logic               BRAM_en;
    logic [0:3]         BRAM_wen;
    logic [31:0]        BRAM_addr;
    logic [31:0]        BRAM_dout;
    logic [31:0]        BRAM_din;
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [BURST_W-1:0] fetch_len;
    logic               fetch_busy;
    logic [31:0]        fetch_data;
    logic               fetch_valid;
    logic               fetch_ready;
    logic               fetch_last;
    logic               fetch_done;

    logic [31:0] model [0:DEPTH-1];
    logic [31:0] expQ [$];
    int          checkCount = 0;
    int          passCount  = 0;

    cmd_fetch_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .BRAM_clk   (BRAM_clk),
        .BRAM_rst   (BRAM_rst),
        .BRAM_en    (BRAM_en),
        .BRAM_wen   (BRAM_wen),
        .BRAM_addr  (BRAM_addr),
        .BRAM_dout  (BRAM_dout),
        .BRAM_din   (BRAM_din),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_len  (fetch_len),
        .fetch_busy (fetch_busy),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_last (fetch_last),
        .fetch_done (fetch_done)
    );

    // Free-running clock
    initial BRAM_clk = 1'b0;
    always #5 BRAM_clk = ~BRAM_clk;

    task automatic tick();
        @(posedge BRAM_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic busWrite(input int word, input logic [31:0] data, input logic [0:3] wen);
        BRAM_en   = 1'b1;
        BRAM_wen  = wen;
        BRAM_addr = 32'(word) << 2;
        BRAM_dout = data;
        tick();
        BRAM_en  = 1'b0;
        BRAM_wen = 4'b0000;
`ifdef CMD_FETCH_BYTE_WRITE_EN
        for (int i = 0; i < 4; i++)
            if (wen[i]) model[word % DEPTH][31-8*i -: 8] = data[31-8*i -: 8];
`else
        if (|wen) model[word % DEPTH] = data;
`endif
    endtask

    task automatic busRead(input int word, output logic [31:0] data);
        BRAM_en   = 1'b1;
        BRAM_wen  = 4'b0000;
        BRAM_addr = 32'(word) << 2;
        tick();
        BRAM_en = 1'b0;
        data    = BRAM_din;
    endtask

    task automatic startBurst(input int addr, input int len);
        fetch_req   = 1'b1;
        fetch_addr  = ADDR_W'(addr);
        fetch_len   = BURST_W'(len);
        fetch_ready = 1'b0;
        tick();
        fetch_req = 1'b0;
        checkOutput("readBusy", fetch_busy, 1);
        checkOutput("readValid", fetch_valid, 0);
        tick();
        checkOutput("firstWordValid", fetch_valid, 1);
    endtask

    // Consume expQ; pat gives a repeating ready sequence (MSB first) unless rnd
    task automatic drainBurst(input int len, input logic [3:0] pat, input bit rnd);
        int idx = 0;
        int cyc = 0;
        logic r;
        while (idx < len && cyc < 200) begin
            r = rnd ? 1'($urandom_range(0, 1)) : pat[3 - (cyc % 4)];
            fetch_ready = r;
            if (rnd) begin
                fetch_req  = 1'($urandom_range(0, 1));
                fetch_addr = ADDR_W'($urandom);
                fetch_len  = BURST_W'($urandom_range(0, 9));
            end
            #1;
            checkOutput("streamValid", fetch_valid, 1);
            checkOutput("streamData", fetch_data, expQ[idx]);
            checkOutput("streamLast", fetch_last, (idx == len - 1));
            checkOutput("streamDone", fetch_done, (r && idx == len - 1));
            if (r) idx++;
            tick();
            cyc++;
        end
        fetch_req   = 1'b0;
        fetch_ready = 1'b0;
        checkOutput("drainWords", idx, len);
        checkOutput("endBusy", fetch_busy, 0);
        checkOutput("endValid", fetch_valid, 0);
        checkOutput("endDone", fetch_done, 0);
    endtask

    task automatic applyStimulus(input int addr, input int len, input logic [3:0] pat, input bit rnd);
        expQ.delete();
        for (int k = 0; k < len; k++) expQ.push_back(model[(addr + k) % DEPTH]);
        startBurst(addr, len);
        drainBurst(len, pat, rnd);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Busy"}, fetch_busy, 0);
        checkOutput({tag, "Valid"}, fetch_valid, 0);
        checkOutput({tag, "Last"}, fetch_last, 0);
        checkOutput({tag, "Done"}, fetch_done, 0);
        checkOutput({tag, "Data"}, fetch_data, 0);
        checkOutput({tag, "Din"}, BRAM_din, 0);
    endtask

    task automatic rejectLen(input int len);
        fetch_req  = 1'b1;
        fetch_addr = ADDR_W'(3);
        fetch_len  = BURST_W'(len);
        tick();
        fetch_req = 1'b0;
        checkOutput("rejectDone", fetch_done, 1);
        checkOutput("rejectBusy", fetch_busy, 0);
        checkOutput("rejectValid", fetch_valid, 0);
        tick();
        checkOutput("rejectDoneOnce", fetch_done, 0);
        checkOutput("rejectValidLater", fetch_valid, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] old40;
        BRAM_rst = 1'b1; BRAM_en = 1'b0; BRAM_wen = 4'b0000;
        BRAM_addr = '0; BRAM_dout = '0;
        fetch_req = 1'b0; fetch_addr = '0; fetch_len = '0; fetch_ready = 1'b0;
        #3;
        checkResetOutputs("reset");
        tick(); tick();
        BRAM_rst = 1'b0;

        $display("[TB] preloading memory");
        for (int w = 0; w < DEPTH; w++) busWrite(w, $urandom, 4'b1111);

        busWrite(4, 32'hDEADBEEF, 4'b1111);
        busRead(4, rd);
        checkOutput("busReadBack", rd, 32'hDEADBEEF);
        busWrite(4, 32'hCAFEF00D, 4'b1111);
        checkOutput("readBeforeWrite", BRAM_din, 32'hDEADBEEF);
        tick();
        checkOutput("busDinHold", BRAM_din, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) busWrite(i, 32'h100 + 32'(i), 4'b1111);

        $display("[TB] ready-high burst");
        applyStimulus(2, 4, 4'b1111, 1'b0);
        checkOutput("burstModelFirst", model[2], 32'h102);
        $display("[TB] toggling-ready burst");
        applyStimulus(2, 4, 4'b1001, 1'b0);
        $display("[TB] wrapping burst");
        applyStimulus(1022, 4, 4'b1111, 1'b0);
        applyStimulus(7, 8, 4'b1101, 1'b0);
        applyStimulus(9, 1, 4'b0111, 1'b0);

        $display("[TB] bad lengths");
        rejectLen(0);
        rejectLen(MAX_BURST + 1);

        $display("[TB] writes during a stalled burst");
        old40 = model[40];
        startBurst(40, 3);
        busWrite(42, 32'h42424242, 4'b1111);
        busWrite(40, 32'h40404040, 4'b1111);
        expQ.delete();
        expQ.push_back(old40);
        expQ.push_back(model[41]);
        expQ.push_back(32'h42424242);
        drainBurst(3, 4'b1111, 1'b0);

        $display("[TB] randomized bursts");
        for (int n = 0; n < 8; n++)
            applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(1, MAX_BURST), 4'b1111, 1'b1);

        $display("[TB] reset mid-burst");
        startBurst(100, 6);
        fetch_ready = 1'b1;
        tick();
        tick();
        checkOutput("preResetData", fetch_data, model[102]);
        #2;
        BRAM_rst  = 1'b1;
        BRAM_en   = 1'b1;
        BRAM_wen  = 4'b1111;
        BRAM_addr = 32'(100) << 2;
        BRAM_dout = 32'h0BAD0BAD;
        #1;
        checkResetOutputs("midReset");
        tick();
        BRAM_rst = 1'b0; BRAM_en = 1'b0; BRAM_wen = 4'b0000; fetch_ready = 1'b0;
        checkOutput("afterResetBusy", fetch_busy, 0);
        checkOutput("afterResetDone", fetch_done, 0);
        for (int w = 100; w < 106; w++) begin
            busRead(w, rd);
            checkOutput("memIntact", rd, model[w]);
        end

        $display("[TB] byte-lane write");
        busWrite(50, 32'hAABBCCDD, 4'b1111);
        busWrite(50, 32'h11223344, 4'b1000);
        busRead(50, rd);
`ifdef CMD_FETCH_BYTE_WRITE_EN
        checkOutput("laneWrite", rd, 32'h11BBCCDD);
`else
        checkOutput("laneWrite", rd, 32'h11223344);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
